// File: rtl/imem_program_loader.sv
// Byte-serial program loader: assembles 32-bit words and writes them
// into instruction memory, holding the core in reset until done.
module imem_program_loader #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       load_count
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_L = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [15:0]       widx_q, widx_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       n_hdr;
  logic              xfer;

  // Byte acceptance is decoded straight from the state.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = (state_q == S_HDR0) ||
                 (state_q == S_HDR1) ||
                 (state_q == S_DATA);
    end
  end

  assign xfer  = in_valid && in_ready;
  assign n_hdr = {in_data, n_q[7:0]};

  // Next-state and output computation.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    bidx_d    = bidx_q;
    widx_d    = widx_q;
    word_d    = word_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_HDR0: begin
        if (xfer) begin
          n_d[7:0] = in_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d[15:8] = in_data;
          if (n_hdr == 16'd0 ||
              {1'b0, n_hdr} > DEPTH_L) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            bidx_d  = 2'd0;
            widx_d  = 16'd0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{bidx_q, 3'b000} +: 8] = in_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = BASE_L + ADDR_W'(widx_q);
            wdata_d = word_d;
            cnt_d   = cnt_q + 16'd1;
          end
        end
      end
      S_WRITE: begin
        if (widx_q == n_q - 16'd1) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          widx_d  = widx_q + 16'd1;
          state_d = S_DATA;
        end
      end
      S_RUN, S_ERR: begin
        if (reload) begin
          state_d   = S_HDR0;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          cnt_d     = 16'd0;
        end
      end
      default: state_d = S_HDR0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_HDR0;
      n_q       <= 16'd0;
      bidx_q    <= 2'd0;
      widx_q    <= 16'd0;
      word_q    <= 32'd0;
      we_q      <= 1'b0;
      addr_q    <= BASE_L;
      wdata_q   <= 32'd0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      bidx_q    <= bidx_d;
      widx_q    <= widx_d;
      word_q    <= word_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_rst_q;
  assign load_done  = done_q;
  assign load_error = err_q;
  assign load_count = cnt_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: two instances, one default
// and one with DEPTH=4, BASE_ADDR=8.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v0 = 1'b0, rl0 = 1'b0;
  logic [7:0]  d0 = 8'h00;
  logic        r0, we0, cr0, dn0, er0;
  logic [9:0]  a0;
  logic [31:0] wd0;
  logic [15:0] c0;

  logic        v1 = 1'b0, rl1 = 1'b0;
  logic [7:0]  d1 = 8'h00;
  logic        r1, we1, cr1, dn1, er1;
  logic [9:0]  a1;
  logic [31:0] wd1;
  logic [15:0] c1;

  int total = 0;
  int bad   = 0;
  int nw0   = 0;
  int nw1   = 0;
  int snap;

  always #5 clk = ~clk;

  imem_program_loader u0 (
    .clk(clk), .reset(rst),
    .in_valid(v0), .in_data(d0), .in_ready(r0),
    .reload(rl0),
    .imem_we(we0), .imem_addr(a0), .imem_wdata(wd0),
    .cpu_reset(cr0), .load_done(dn0),
    .load_error(er0), .load_count(c0)
  );

  imem_program_loader #(.DEPTH(4), .BASE_ADDR(8)) u1 (
    .clk(clk), .reset(rst),
    .in_valid(v1), .in_data(d1), .in_ready(r1),
    .reload(rl1),
    .imem_we(we1), .imem_addr(a1), .imem_wdata(wd1),
    .cpu_reset(cr1), .load_done(dn1),
    .load_error(er1), .load_count(c1)
  );

  // Count write pulses away from the active edge.
  always @(negedge clk) begin
    if (we0) nw0++;
    if (we1) nw1++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input logic [7:0] b);
    int k;
    k = 0;
    if (u == 0) begin v0 = 1'b1; d0 = b; end
    else begin v1 = 1'b1; d1 = b; end
    @(negedge clk);
    while (!(u == 0 ? r0 : r1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept", 32'(u == 0 ? r0 : r1), 32'd1);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic gsend(input logic [7:0] b);
    repeat (3) step();
    send(0, b);
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_cpu", 32'(cr0), 1);
    chk("rst_we", 32'(we0), 0);
    chk("rst_addr", 32'(a0), 0);
    chk("rst_wd", wd0, 0);
    chk("rst_done", 32'(dn0), 0);
    chk("rst_err", 32'(er0), 0);
    chk("rst_cnt", 32'(c0), 0);
    chk("rst_rdy", 32'(r0), 0);
    chk("rst_addr1", 32'(a1), 8);
    rst = 1'b0;
    #1;
    chk("rdy_after", 32'(r0), 1);

    // Nominal two-word load
    send(0, 8'h02); send(0, 8'h00);
    send(0, 8'h01); send(0, 8'h00);
    send(0, 8'h00); send(0, 8'h00);
    chk("nom_we0", 32'(we0), 1);
    chk("nom_a0", 32'(a0), 0);
    chk("nom_d0", wd0, 32'h1);
    chk("nom_c0", 32'(c0), 1);
    send(0, 8'hEF); send(0, 8'hBE);
    send(0, 8'hAD); send(0, 8'hDE);
    chk("nom_we1", 32'(we0), 1);
    chk("nom_a1", 32'(a0), 1);
    chk("nom_d1", wd0, 32'hDEADBEEF);
    chk("nom_c1", 32'(c0), 2);
    chk("nom_cpu_hold", 32'(cr0), 1);
    chk("nom_done_pre", 32'(dn0), 0);
    step();
    chk("nom_cpu", 32'(cr0), 0);
    chk("nom_done", 32'(dn0), 1);
    chk("nom_we_off", 32'(we0), 0);
    chk("nom_nw", nw0, 2);
    chk("nom_rdy", 32'(r0), 0);
    v0 = 1'b1; d0 = 8'h55;
    repeat (3) step();
    chk("stray_rdy", 32'(r0), 0);
    chk("stray_nw", nw0, 2);
    chk("stray_done", 32'(dn0), 1);
    v0 = 1'b0;

    // Reload with a one-word image
    rl0 = 1'b1;
    step();
    rl0 = 1'b0;
    chk("rl_cpu", 32'(cr0), 1);
    chk("rl_done", 32'(dn0), 0);
    chk("rl_cnt", 32'(c0), 0);
    chk("rl_rdy", 32'(r0), 1);
    send(0, 8'h01); send(0, 8'h00);
    send(0, 8'h78); send(0, 8'h56);
    rl0 = 1'b1;
    step();
    rl0 = 1'b0;
    chk("rl_data_rdy", 32'(r0), 1);
    chk("rl_data_cpu", 32'(cr0), 1);
    send(0, 8'h34); send(0, 8'h12);
    chk("rl_we", 32'(we0), 1);
    chk("rl_a", 32'(a0), 0);
    chk("rl_d", wd0, 32'h12345678);
    chk("rl_c", 32'(c0), 1);
    step();
    chk("rl_run", 32'(dn0), 1);
    chk("rl_nw", nw0, 3);

    // Same nominal image with bubbles
    rl0 = 1'b1;
    step();
    rl0 = 1'b0;
    gsend(8'h02); gsend(8'h00);
    gsend(8'h01); gsend(8'h00);
    gsend(8'h00); gsend(8'h00);
    chk("bub_d0", wd0, 32'h1);
    chk("bub_a0", 32'(a0), 0);
    gsend(8'hEF); gsend(8'hBE);
    gsend(8'hAD);
    repeat (3) step();
    chk("bub_cpu_hold", 32'(cr0), 1);
    chk("bub_nw_mid", nw0, 4);
    send(0, 8'hDE);
    chk("bub_a1", 32'(a0), 1);
    chk("bub_d1", wd0, 32'hDEADBEEF);
    step();
    chk("bub_cpu", 32'(cr0), 0);
    chk("bub_done", 32'(dn0), 1);
    chk("bub_cnt", 32'(c0), 2);

    // Bad header: N=0
    rl0 = 1'b1;
    step();
    rl0 = 1'b0;
    snap = nw0;
    send(0, 8'h00); send(0, 8'h00);
    chk("n0_err", 32'(er0), 1);
    chk("n0_rdy", 32'(r0), 0);
    chk("n0_cpu", 32'(cr0), 1);
    v0 = 1'b1;
    repeat (3) step();
    v0 = 1'b0;
    chk("n0_nw", nw0, snap);
    chk("n0_err_hold", 32'(er0), 1);
    rl0 = 1'b1;
    step();
    rl0 = 1'b0;
    chk("err_rl_clr", 32'(er0), 0);
    chk("err_rl_rdy", 32'(r0), 1);

    // Bad header: N=1025
    send(0, 8'h01); send(0, 8'h04);
    chk("big_err", 32'(er0), 1);
    chk("big_rdy", 32'(r0), 0);
    chk("big_cpu", 32'(cr0), 1);
    repeat (2) step();
    chk("big_nw", nw0, snap);
    rl0 = 1'b1;
    step();
    rl0 = 1'b0;

    // Reset in the middle of word 0
    send(0, 8'h01); send(0, 8'h00);
    send(0, 8'hAA); send(0, 8'hBB);
    rst = 1'b1;
    #1;
    chk("mr_rdy", 32'(r0), 0);
    repeat (2) step();
    chk("mr_cpu", 32'(cr0), 1);
    chk("mr_nw", nw0, snap);
    rst = 1'b0;
    step();
    send(0, 8'h01); send(0, 8'h00);
    send(0, 8'hAA); send(0, 8'hBB);
    send(0, 8'hCC); send(0, 8'hDD);
    chk("mr_a", 32'(a0), 0);
    chk("mr_d", wd0, 32'hDDCCBBAA);
    step();
    chk("mr_nw1", nw0, snap + 1);
    chk("mr_done", 32'(dn0), 1);

    // Max size on the small instance
    send(1, 8'h04); send(1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      send(1, 8'h10 + 8'(i));
      send(1, 8'h20 + 8'(i));
      send(1, 8'h30 + 8'(i));
      send(1, 8'h40 + 8'(i));
      chk("max_we", 32'(we1), 1);
      chk("max_a", 32'(a1), 32'(8 + i));
      chk("max_d", wd1,
          {8'h40 + 8'(i), 8'h30 + 8'(i),
           8'h20 + 8'(i), 8'h10 + 8'(i)});
      chk("max_c", 32'(c1), 32'(i + 1));
    end
    step();
    chk("max_done", 32'(dn1), 1);
    chk("max_cpu", 32'(cr1), 0);
    chk("max_nw", nw1, 4);
    v1 = 1'b1; d1 = 8'h99;
    repeat (3) step();
    chk("max_stray", 32'(r1), 0);
    v1 = 1'b0;
    step();
    chk("max_nw2", nw1, 4);

    // N=5 exceeds the small depth
    rl1 = 1'b1;
    step();
    rl1 = 1'b0;
    send(1, 8'h05); send(1, 8'h00);
    chk("max_over_err", 32'(er1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
